alu_exec_sequencer: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 49 ++++
 rtl/alu_exec_sequencer_alu_op_decoder.sv | 41 ++++
 rtl/alu_exec_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the execute-stage controller: RV32I opcodes, ALU op codes,
// sequencer states and the opcode classes consumed by the ALU op decoder.
package alu_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // How the decoder should interpret funct3/funct7_5 for the current pass.
  typedef enum logic [2:0] {
    CLS_ADD    = 3'd0,
    CLS_OP     = 3'd1,
    CLS_OP_IMM = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_PASS_B = 3'd4
  } op_class_e;

  function automatic logic is_two_pass(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/alu_exec_sequencer_alu_op_decoder.sv
// Combinational ALU op decode from opcode class, funct3 and funct7_5.
// Shared with other pipeline stages, so it carries no sequencing knowledge.
module alu_op_decoder
  import alu_ctrl_pkg::*;
(
  input  op_class_e  op_class,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_e    alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (op_class)
      CLS_OP, CLS_OP_IMM: begin
        case (funct3)
          // Immediate forms never subtract: bit 30 is part of the immediate for ADDI.
          3'b000:  alu_op = (op_class == CLS_OP && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      CLS_BRANCH: begin
        case (funct3[2:1])
          2'b00:   alu_op = ALU_SUB;
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: alu_op = ALU_ADD;
        endcase
      end
      CLS_PASS_B: alu_op = ALU_PASS_B;
      default:    alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Execute-stage controller: accepts one decoded instruction, steers the operand muxes
// and ALU through one or two passes, strobes the result registers, then reports done.
module alu_exec_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int OPCODE_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7_5,
  output logic                d1_sel,
  output logic                d2_sel,
  output logic                imm_four_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                rd_capture,
  output logic                tgt_capture,
  output logic                cmp_capture,
  output logic                illegal,
  output logic                out_valid,
  input  logic                out_ready
);

  state_e              state, state_next;
  logic [OPCODE_W-1:0] opcode_q;
  logic [2:0]          funct3_q;
  logic                funct7_5_q;
  op_class_e           op_class;
  alu_op_e             dec_op;
  logic                instr_bad;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7_5_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && in_valid) begin
        opcode_q   <= opcode;
        funct3_q   <= funct3;
        funct7_5_q <= funct7_5;
      end
    end
  end

  always_comb begin
    case (opcode_q)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR: instr_bad = 1'b0;
      OPC_BRANCH: instr_bad = (funct3_q[2:1] == 2'b01);
      default:    instr_bad = 1'b1;
    endcase
  end

  // NOTE: every output and next-state gets a default first, so no path infers a latch.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    d1_sel       = 1'b0;
    d2_sel       = 1'b0;
    imm_four_sel = 1'b0;
    op_class     = CLS_ADD;
    rd_capture   = 1'b0;
    tgt_capture  = 1'b0;
    cmp_capture  = 1'b0;
    illegal      = 1'b0;
    out_valid    = 1'b0;

    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_PASS1;
      end

      ST_PASS1: begin
        state_next = (is_two_pass(opcode_q) && !instr_bad) ? ST_PASS2 : ST_DONE;
        if (!instr_bad) begin
          case (opcode_q)
            OPC_OP: begin
              op_class   = CLS_OP;
              rd_capture = 1'b1;
            end
            OPC_OP_IMM: begin
              d2_sel     = 1'b1;
              op_class   = CLS_OP_IMM;
              rd_capture = 1'b1;
            end
            OPC_LUI: begin
              d2_sel     = 1'b1;
              op_class   = CLS_PASS_B;
              rd_capture = 1'b1;
            end
            OPC_AUIPC: begin
              d1_sel     = 1'b1;
              d2_sel     = 1'b1;
              rd_capture = 1'b1;
            end
            OPC_LOAD, OPC_STORE: begin
              d2_sel     = 1'b1;
              rd_capture = 1'b1;
            end
            OPC_BRANCH: begin
              op_class    = CLS_BRANCH;
              cmp_capture = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
              // Link value: pc + 4.
              d1_sel       = 1'b1;
              d2_sel       = 1'b1;
              imm_four_sel = 1'b1;
              rd_capture   = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_PASS2: begin
        state_next  = ST_DONE;
        d1_sel      = (opcode_q != OPC_JALR);
        d2_sel      = 1'b1;
        tgt_capture = 1'b1;
      end

      default: begin
        out_valid = 1'b1;
        illegal   = instr_bad;
        if (out_ready) state_next = ST_IDLE;
      end
    endcase
  end

  alu_op_decoder u_alu_op_decoder (
    .op_class (op_class),
    .funct3   (funct3_q),
    .funct7_5 (funct7_5_q),
    .alu_op   (dec_op)
  );

  assign alu_op = ALU_OP_W'(dec_op);

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer: a table of instructions with expected per-pass
// outputs, plus hand-written sequences for completion back-pressure and mid-flight reset.
module tb_alu_exec_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       d1_sel;
  logic       d2_sel;
  logic       imm_four_sel;
  logic [3:0] alu_op;
  logic       rd_capture;
  logic       tgt_capture;
  logic       cmp_capture;
  logic       illegal;
  logic       out_valid;
  logic       out_ready;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_sequencer #(.ALU_OP_W(4), .OPCODE_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7_5     (funct7_5),
    .d1_sel       (d1_sel),
    .d2_sel       (d2_sel),
    .imm_four_sel (imm_four_sel),
    .alu_op       (alu_op),
    .rd_capture   (rd_capture),
    .tgt_capture  (tgt_capture),
    .cmp_capture  (cmp_capture),
    .illegal      (illegal),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {d1, d2, imm4, alu_op[3:0], rd, tgt, cmp, out_valid, in_ready, illegal}
  localparam logic [12:0] IDLE_PAT = 13'd2;

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic        two;
    logic [12:0] p1;
    logic [12:0] p2;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [12:0] outs();
    return {d1_sel, d2_sel, imm_four_sel, alu_op, rd_capture, tgt_capture, cmp_capture,
            out_valid, in_ready, illegal};
  endfunction

  function automatic logic [12:0] mk(input logic d1, input logic d2, input logic i4,
                                     input logic [3:0] op, input logic rd,
                                     input logic tgt, input logic cmp);
    return {d1, d2, i4, op, rd, tgt, cmp, 3'b000};
  endfunction

  function automatic logic [12:0] done_pat(input logic ill);
    return {10'b0, 1'b1, 1'b0, ill};
  endfunction

  function automatic vec_t v(input string n, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic two, input logic [12:0] p1,
                             input logic [12:0] p2, input logic ill);
    vec_t r;
    r.name = n; r.opc = o; r.f3 = f3; r.f7 = f7; r.two = two;
    r.p1 = p1; r.p2 = p2; r.ill = ill;
    return r;
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (d1 d2 i4 op4 rd tgt cmp ov ir ill)",
               name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int guard = 0;
    while (!in_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (!in_ready) begin
      n_errors++;
      $display("FAIL %s_wait_ready: got in_ready=0 expected 1 within 10 cycles", name);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_vec(input vec_t t);
    wait_ready(t.name);
    opcode    = t.opc;
    funct3    = t.f3;
    funct7_5  = t.f7;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({t.name, "_pass1"}, outs(), t.p1);
    if (t.two) begin
      @(negedge clk);
      check({t.name, "_pass2"}, outs(), t.p2);
    end
    @(negedge clk);
    check({t.name, "_done"}, outs(), done_pat(t.ill));
    @(negedge clk);
    check({t.name, "_idle"}, outs(), IDLE_PAT);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = '0;
    funct3    = '0;
    funct7_5  = 1'b0;

    vecs.push_back(v("add",   7'b0110011, 3'b000, 1'b0, 1'b0, mk(0,0,0,4'd0,1,0,0),  '0, 1'b0));
    vecs.push_back(v("sub",   7'b0110011, 3'b000, 1'b1, 1'b0, mk(0,0,0,4'd1,1,0,0),  '0, 1'b0));
    vecs.push_back(v("sra",   7'b0110011, 3'b101, 1'b1, 1'b0, mk(0,0,0,4'd7,1,0,0),  '0, 1'b0));
    vecs.push_back(v("srl",   7'b0110011, 3'b101, 1'b0, 1'b0, mk(0,0,0,4'd6,1,0,0),  '0, 1'b0));
    vecs.push_back(v("sltu",  7'b0110011, 3'b011, 1'b0, 1'b0, mk(0,0,0,4'd4,1,0,0),  '0, 1'b0));
    vecs.push_back(v("and",   7'b0110011, 3'b111, 1'b0, 1'b0, mk(0,0,0,4'd9,1,0,0),  '0, 1'b0));
    vecs.push_back(v("addi7", 7'b0010011, 3'b000, 1'b1, 1'b0, mk(0,1,0,4'd0,1,0,0),  '0, 1'b0));
    vecs.push_back(v("srai",  7'b0010011, 3'b101, 1'b1, 1'b0, mk(0,1,0,4'd7,1,0,0),  '0, 1'b0));
    vecs.push_back(v("xori",  7'b0010011, 3'b100, 1'b0, 1'b0, mk(0,1,0,4'd5,1,0,0),  '0, 1'b0));
    vecs.push_back(v("lui",   7'b0110111, 3'b000, 1'b0, 1'b0, mk(0,1,0,4'd10,1,0,0), '0, 1'b0));
    vecs.push_back(v("auipc", 7'b0010111, 3'b000, 1'b0, 1'b0, mk(1,1,0,4'd0,1,0,0),  '0, 1'b0));
    vecs.push_back(v("load",  7'b0000011, 3'b010, 1'b0, 1'b0, mk(0,1,0,4'd0,1,0,0),  '0, 1'b0));
    vecs.push_back(v("store", 7'b0100011, 3'b010, 1'b0, 1'b0, mk(0,1,0,4'd0,1,0,0),  '0, 1'b0));
    vecs.push_back(v("bltu",  7'b1100011, 3'b110, 1'b0, 1'b1, mk(0,0,0,4'd4,0,0,1),
                     mk(1,1,0,4'd0,0,1,0), 1'b0));
    vecs.push_back(v("bne",   7'b1100011, 3'b001, 1'b0, 1'b1, mk(0,0,0,4'd1,0,0,1),
                     mk(1,1,0,4'd0,0,1,0), 1'b0));
    vecs.push_back(v("bge",   7'b1100011, 3'b101, 1'b0, 1'b1, mk(0,0,0,4'd3,0,0,1),
                     mk(1,1,0,4'd0,0,1,0), 1'b0));
    vecs.push_back(v("jal",   7'b1101111, 3'b000, 1'b0, 1'b1, mk(1,1,1,4'd0,1,0,0),
                     mk(1,1,0,4'd0,0,1,0), 1'b0));
    vecs.push_back(v("jalr",  7'b1100111, 3'b000, 1'b0, 1'b1, mk(1,1,1,4'd0,1,0,0),
                     mk(0,1,0,4'd0,0,1,0), 1'b0));
    vecs.push_back(v("badop", 7'b1111111, 3'b000, 1'b0, 1'b0, '0, '0, 1'b1));
    vecs.push_back(v("bf3_2", 7'b1100011, 3'b010, 1'b0, 1'b0, '0, '0, 1'b1));

    // Reset values observed while reset is still held.
    @(posedge clk);
    @(negedge clk);
    check("reset_state", outs(), IDLE_PAT);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", outs(), IDLE_PAT);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Completion back-pressure: DONE holds and ignores a new instruction.
    out_ready = 1'b0;
    opcode    = 7'b0110011;
    funct3    = 3'b100;
    funct7_5  = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    opcode = 7'b0110111;
    check("stall_pass1", outs(), mk(0,0,0,4'd5,1,0,0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall_done_%0d", k), outs(), done_pat(1'b0));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("stall_release_idle", outs(), IDLE_PAT);
    @(negedge clk);
    check("stall_no_accept", outs(), IDLE_PAT);

    // Reset during BRANCH PASS1 abandons the instruction.
    opcode   = 7'b1100011;
    funct3   = 3'b000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_branch_pass1", outs(), mk(0,0,0,4'd1,0,0,1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_idle", outs(), IDLE_PAT);
    @(negedge clk);
    check("rst_mid_no_done", outs(), IDLE_PAT);

    // Sequencer still works after the abandoned instruction.
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
